// File: rtl/div.sv
// ============================================================================
// Module      : div
// Description : Sequential 24-bit by 8-bit unsigned restoring divider.
//               One quotient bit is resolved per clock, MSB first, giving a
//               fixed 24-cycle busy window per division. Results, the done
//               pulse and the divide-by-zero flag are all registered.
//               Optional feature macro: DIV_ZERO_DETECT_EN
//                 defined   -> a zero divisor short-circuits to a one-edge
//                              completion with err_o = 1 (busy_o stays 0)
//                 undefined -> err_o is tied to 0 and a zero divisor runs
//                              through the normal 24-step algorithm
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] a_bi,
    input  logic [7:0]  b_bi,
    input  logic        start_i,
    output logic        busy_o,
    output logic [23:0] q_bo,
    output logic [7:0]  r_bo,
    output logic        done_o,
    output logic        err_o
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WORK = 1'b1
    } state_t;

    localparam logic [4:0]  c_LAST_STEP = 5'd23;
    localparam logic [23:0] c_ALL_ONES  = 24'hFFFFFF;

    // ------------------------------------------------------------------------
    // Working registers
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [4:0]  r_cnt;     // step counter, 0..23
    logic [8:0]  r_rem;     // partial remainder
    logic [23:0] r_dvd;     // latched dividend, shifted left one bit per step
    logic [7:0]  r_dvs;     // latched divisor
    logic [23:0] r_quot;    // quotient bits accumulated so far
    logic [23:0] r_q;
    logic [7:0]  r_r;
    logic        r_done;

    // ------------------------------------------------------------------------
    // Combinational restoring step
    // ------------------------------------------------------------------------
    logic [8:0]  w_shift;
    logic [8:0]  w_dvs_ext;
    logic        w_ge;
    logic [8:0]  w_rem_nxt;
    logic [23:0] w_quot_nxt;
    logic        w_last;
    logic        w_zero_start;
    logic        w_unused;

    // One restoring step: shift next dividend bit in, trial-subtract the
    // zero-extended divisor at full 9-bit width, keep or restore.
    always_comb begin
        w_shift    = {r_rem[7:0], r_dvd[23]};
        w_dvs_ext  = {1'b0, r_dvs};
        w_ge       = (w_shift >= w_dvs_ext);
        w_rem_nxt  = w_shift;
        if (w_ge) begin
            w_rem_nxt = w_shift - w_dvs_ext;
        end
        w_quot_nxt = {r_quot[22:0], w_ge};
        w_last     = (r_cnt == c_LAST_STEP);
    end

    // The remainder MSB only becomes set for a zero divisor, where it is
    // shifted out on the next step; it never feeds the datapath.
    assign w_unused = r_rem[8];

`ifdef DIV_ZERO_DETECT_EN
    logic r_err;

    // A start with a zero divisor bypasses the iterative datapath.
    assign w_zero_start = (b_bi == 8'd0);
    assign err_o        = r_err;
`else
    assign w_zero_start = 1'b0;
    assign err_o        = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy_o = (r_state == ST_WORK);
    assign q_bo   = r_q;
    assign r_bo   = r_r;
    assign done_o = r_done;

    // FSM, datapath registers and registered results.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_rem   <= 9'd0;
            r_dvd   <= 24'd0;
            r_dvs   <= 8'd0;
            r_quot  <= 24'd0;
            r_q     <= 24'd0;
            r_r     <= 8'd0;
            r_done  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            r_err   <= 1'b0;
`endif
        end else begin
            // done is a single-cycle pulse unless re-asserted below
            r_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (w_zero_start) begin
                            // Immediate completion for a divide by zero;
                            // results mimic what the full algorithm yields.
                            r_q    <= c_ALL_ONES;
                            r_r    <= a_bi[7:0];
                            r_done <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                            r_err  <= 1'b1;
`endif
                        end else begin
                            r_dvd   <= a_bi;
                            r_dvs   <= b_bi;
                            r_cnt   <= 5'd0;
                            r_rem   <= 9'd0;
                            r_quot  <= 24'd0;
                            r_state <= ST_WORK;
                        end
                    end
                end

                ST_WORK: begin
                    // start_i is deliberately not looked at here so the
                    // latched operands stay stable for the whole division.
                    r_rem  <= w_rem_nxt;
                    r_quot <= w_quot_nxt;
                    r_dvd  <= {r_dvd[22:0], 1'b0};
                    if (w_last) begin
                        r_q     <= w_quot_nxt;
                        r_r     <= w_rem_nxt[7:0];
                        r_done  <= 1'b1;
                        r_cnt   <= 5'd0;
                        r_state <= ST_IDLE;
`ifdef DIV_ZERO_DETECT_EN
                        r_err   <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none

module tb_div;

    logic        clk_i;
    logic        rst_i;
    logic [23:0] a_bi;
    logic [7:0]  b_bi;
    logic        start_i;
    logic        busy_o;
    logic [23:0] q_bo;
    logic [7:0]  r_bo;
    logic        done_o;
    logic        err_o;

    int total;
    int bad;

    div u_dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .a_bi    (a_bi),
        .b_bi    (b_bi),
        .start_i (start_i),
        .busy_o  (busy_o),
        .q_bo    (q_bo),
        .r_bo    (r_bo),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive operands with start for one edge; returns 1 ns after that edge.
    task automatic start_op(input logic [23:0] a, input logic [7:0] b);
        a_bi    = a;
        b_bi    = b;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Wait (bounded) for done_o; count edges waited and busy samples seen.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (done_o !== 1'b1 && edges < 40) begin
            if (busy_o === 1'b1) busy_cnt++;
            @(posedge clk_i);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        rst_i   = 1'b0;
        start_i = 1'b0;
        a_bi    = 24'd0;
        b_bi    = 8'd0;
        #3;
        total++;
        if ({busy_o, q_bo, r_bo, done_o, err_o} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b q=%h r=%h done=%b err=%b, want all 0",
                     busy_o, q_bo, r_bo, done_o, err_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic test_basic;
        int edges, bc;
        start_op(24'd1000, 8'd7);
        total++;
        if (busy_o !== 1'b1) begin
            bad++; $display("FAIL basic_busy_start: got %b want 1", busy_o);
        end
        wait_done(edges, bc);
        total++;
        if (edges !== 24 || bc !== 24) begin
            bad++; $display("FAIL basic_latency: got edges=%0d busy=%0d want 24/24", edges, bc);
        end
        total++;
        if (q_bo !== 24'd142 || r_bo !== 8'd6 || err_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL basic_result: got q=%0d r=%0d err=%b busy=%b want 142/6/0/0",
                            q_bo, r_bo, err_o, busy_o);
        end
        @(posedge clk_i);
        #1;
        total++;
        if (done_o !== 1'b0 || q_bo !== 24'd142 || r_bo !== 8'd6) begin
            bad++; $display("FAIL basic_pulse_hold: got done=%b q=%0d r=%0d want 0/142/6",
                            done_o, q_bo, r_bo);
        end
    endtask

    task automatic test_max;
        int edges, bc;
        start_op(24'hFFFFFF, 8'hFF);
        wait_done(edges, bc);
        total++;
        if (edges !== 24 || q_bo !== 24'h010101 || r_bo !== 8'h00) begin
            bad++; $display("FAIL max_div: got edges=%0d q=%h r=%h want 24/010101/00",
                            edges, q_bo, r_bo);
        end
        @(posedge clk_i);
        #1;
        start_op(24'd5, 8'd9);
        wait_done(edges, bc);
        total++;
        if (edges !== 24 || q_bo !== 24'd0 || r_bo !== 8'd5) begin
            bad++; $display("FAIL small_div: got edges=%0d q=%0d r=%0d want 24/0/5",
                            edges, q_bo, r_bo);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_zero;
        int edges, bc;
        start_op(24'd300, 8'd0);
`ifdef DIV_ZERO_DETECT_EN
        total++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b1 ||
            q_bo !== 24'hFFFFFF || r_bo !== 8'h2C) begin
            bad++; $display("FAIL zero_detect: got done=%b busy=%b err=%b q=%h r=%h want 1/0/1/ffffff/2c",
                            done_o, busy_o, err_o, q_bo, r_bo);
        end
        @(posedge clk_i);
        #1;
        total++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b1) begin
            bad++; $display("FAIL zero_after: got done=%b busy=%b err=%b want 0/0/1",
                            done_o, busy_o, err_o);
        end
        start_op(24'd1000, 8'd7);
        wait_done(edges, bc);
        total++;
        if (err_o !== 1'b0 || q_bo !== 24'd142 || r_bo !== 8'd6) begin
            bad++; $display("FAIL zero_err_clear: got err=%b q=%0d r=%0d want 0/142/6",
                            err_o, q_bo, r_bo);
        end
`else
        wait_done(edges, bc);
        total++;
        if (edges !== 24 || bc !== 24 || err_o !== 1'b0 ||
            q_bo !== 24'hFFFFFF || r_bo !== 8'h2C) begin
            bad++; $display("FAIL zero_normal: got edges=%0d busy=%0d err=%b q=%h r=%h want 24/24/0/ffffff/2c",
                            edges, bc, err_o, q_bo, r_bo);
        end
`endif
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_back_to_back;
        int edges, bc;
        start_op(24'd1000, 8'd7);
        repeat (9) begin
            @(posedge clk_i);
            #1;
        end
        // Start with new operands while busy: must be ignored.
        a_bi    = 24'd50;
        b_bi    = 8'd5;
        start_i = 1'b1;
        repeat (2) begin
            @(posedge clk_i);
            #1;
        end
        start_i = 1'b0;
        wait_done(edges, bc);
        total++;
        if (edges !== 13 || q_bo !== 24'd142 || r_bo !== 8'd6) begin
            bad++; $display("FAIL ignore_start: got edges=%0d q=%0d r=%0d want 13/142/6",
                            edges, q_bo, r_bo);
        end
        // Start in the done cycle: accepted with no dead cycle.
        start_op(24'd50, 8'd5);
        total++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            bad++; $display("FAIL b2b_accept: got busy=%b done=%b want 1/0", busy_o, done_o);
        end
        wait_done(edges, bc);
        total++;
        if (edges !== 24 || q_bo !== 24'd10 || r_bo !== 8'd0) begin
            bad++; $display("FAIL b2b_result: got edges=%0d q=%0d r=%0d want 24/10/0",
                            edges, q_bo, r_bo);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset_abort;
        int edges, bc;
        int seen_done;
        start_op(24'd1000, 8'd7);
        repeat (11) begin
            @(posedge clk_i);
            #1;
        end
        #3;
        rst_i = 1'b0;
        #1;
        total++;
        if ({busy_o, q_bo, r_bo, done_o, err_o} !== 35'd0) begin
            bad++; $display("FAIL abort_outputs: got busy=%b q=%h r=%h done=%b err=%b want all 0",
                            busy_o, q_bo, r_bo, done_o, err_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 30; i++) begin
            if (done_o !== 1'b0 || busy_o !== 1'b0 || q_bo !== 24'd0) seen_done++;
            @(posedge clk_i);
            #1;
        end
        total++;
        if (seen_done !== 0) begin
            bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", seen_done);
        end
        start_op(24'd81, 8'd9);
        wait_done(edges, bc);
        total++;
        if (edges !== 24 || q_bo !== 24'd9 || r_bo !== 8'd0) begin
            bad++; $display("FAIL post_reset: got edges=%0d q=%0d r=%0d want 24/9/0",
                            edges, q_bo, r_bo);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
